// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store slave with fixed wait
// states, an internal word array and a held response.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_write, req_addr, req_wdata  request fields (latched in IDLE)
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              response payload (held until accepted)
//   txn_count                       completed response handshakes (wraps)
//
// Build option: define DMEM_MISALIGN_TRAP_EN to fault accesses whose
// address is not word aligned (rsp_err=1, rdata=0, no array write).
module dmem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] txn_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]            r_cnt;
  logic                  r_write;
  logic [DEPTH_LOG2+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [15:0]           r_txn;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_access;
  logic                  w_done;
  logic                  w_mis;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_unused_addr;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_access = (r_state == S_WAIT) && (r_cnt == 8'd0);
  assign w_done   = (r_state == S_RESP) && rsp_ready;
  assign w_idx    = r_addr[DEPTH_LOG2+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis = |r_addr[1:0];
`else
  assign w_mis = 1'b0;
`endif

  // Upper address bits alias; byte offset only matters with the trap.
  assign w_unused_addr = ^{req_addr[31:DEPTH_LOG2+2], r_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 8'd0) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 8'd0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
      r_txn   <= 16'd0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 8'(WAIT_CYCLES);
        r_write <= req_write;
        r_addr  <= req_addr[DEPTH_LOG2+1:0];
        r_wdata <= req_wdata;
      end
      if (r_state == S_WAIT && r_cnt != 8'd0)
        r_cnt <= r_cnt - 8'd1;
      if (w_access) begin
        r_err   <= w_mis;
        r_rdata <= (r_write || w_mis) ? 32'd0 : r_mem[w_idx];
      end
      if (w_done)
        r_txn <= r_txn + 16'd1;
    end
  end

  // Array is deliberately not reset; a reset in WAIT blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && w_access && r_write && !w_mis)
      r_mem[w_idx] <= r_wdata;
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign txn_count = r_txn;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus
// randomized traffic against an associative-array memory model.
module tb_dmem_responder;

  localparam int DL2   = 8;
  localparam int WAITC = 1;
  localparam int DEPTH = 1 << DL2;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] txn_count;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mem_m [int];
  logic [15:0] exp_txn = 16'd0;

  dmem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WAITC)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  // Reference: word index wraps modulo array size, misaligned faults
  // only with the trap, stores return 0, unknown words are unchecked.
  task automatic predict(input logic w, input logic [31:0] a,
                         input logic [31:0] d, output logic known,
                         output logic [31:0] erd, output logic eer);
    int idx;
    logic mis;
    idx = int'((a >> 2) % DEPTH);
    mis = TRAP && (a[1:0] != 2'b00);
    eer = mis;
    known = 1'b1;
    erd = 32'd0;
    if (!w && !mis) begin
      if (mem_m.exists(idx)) erd = mem_m[idx];
      else known = 1'b0;
    end
    if (w && !mis) mem_m[idx] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_txn = 16'd0;
  endtask

  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i <= 300; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_txn(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int hold,
                        input logic poke, output int lat,
                        output logic [31:0] rd, output logic er,
                        output logic stable, output logic idle_ok);
    issue(w, a, d);
    wait_valid(lat);
    rd = rsp_rdata;
    er = rsp_err;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h0000_0BAD;
      end
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== rd || rsp_err !== er || req_ready)
        stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    idle_ok = req_ready && !rsp_valid;
    exp_txn = exp_txn + 16'd1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || txn_count !== 16'd0 ||
        rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset: rdy=%b vld=%b txn=%0d rd=%h err=%b want 1 0 0 0 0",
               req_ready, rsp_valid, txn_count, rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_store_load();
    int lat;
    logic [31:0] rd, erd;
    logic er, st, ok, kn, eer;
    predict(1'b1, 32'h10, 32'hDEADBEEF, kn, erd, eer);
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, lat, rd, er, st, ok);
    n_chk++;
    if (lat !== WAITC + 1 || rd !== 32'd0 || er !== 1'b0 || !ok) begin
      n_err++;
      $display("FAIL sw_lat: lat=%0d rd=%h err=%b idle=%b want %0d 0 0 1",
               lat, rd, er, ok, WAITC + 1);
    end
    predict(1'b0, 32'h10, 32'd0, kn, erd, eer);
    do_txn(1'b0, 32'h10, 32'd0, 0, 1'b0, lat, rd, er, st, ok);
    n_chk++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== WAITC + 1) begin
      n_err++;
      $display("FAIL lw_data: rd=%h err=%b lat=%0d want deadbeef 0 %0d",
               rd, er, lat, WAITC + 1);
    end
    n_chk++;
    if (txn_count !== 16'd2) begin
      n_err++;
      $display("FAIL txn2: got %0d want 2", txn_count);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] rd, erd;
    logic er, st, ok, kn, eer;
    predict(1'b0, 32'h10, 32'd0, kn, erd, eer);
    do_txn(1'b0, 32'h10, 32'd0, 5, 1'b1, lat, rd, er, st, ok);
    n_chk++;
    if (!st || !ok || rd !== erd) begin
      n_err++;
      $display("FAIL backpressure: stable=%b idle=%b rd=%h want 1 1 %h",
               st, ok, rd, erd);
    end
    n_chk++;
    if (txn_count !== exp_txn) begin
      n_err++;
      $display("FAIL bp_txn: got %0d want %0d", txn_count, exp_txn);
    end
    predict(1'b0, 32'h10, 32'd0, kn, erd, eer);
    do_txn(1'b0, 32'h10, 32'd0, 0, 1'b0, lat, rd, er, st, ok);
    n_chk++;
    if (rd !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL bp_noaccept: word 0x10=%h want deadbeef", rd);
    end
  endtask

  task automatic test_alias();
    int lat;
    logic [31:0] rd, erd;
    logic er, st, ok, kn, eer;
    predict(1'b1, 32'h400, 32'h1234, kn, erd, eer);
    do_txn(1'b1, 32'h400, 32'h1234, 0, 1'b0, lat, rd, er, st, ok);
    predict(1'b0, 32'h0, 32'd0, kn, erd, eer);
    do_txn(1'b0, 32'h0, 32'd0, 1, 1'b0, lat, rd, er, st, ok);
    n_chk++;
    if (rd !== 32'h1234 || er !== 1'b0) begin
      n_err++;
      $display("FAIL alias: rd=%h err=%b want 00001234 0", rd, er);
    end
  endtask

  task automatic test_misalign();
    int lat;
    logic [31:0] rd, erd;
    logic er, st, ok, kn, eer;
    predict(1'b0, 32'h13, 32'd0, kn, erd, eer);
    do_txn(1'b0, 32'h13, 32'd0, 0, 1'b0, lat, rd, er, st, ok);
    n_chk++;
    if (rd !== (TRAP ? 32'd0 : 32'hDEADBEEF) || er !== TRAP ||
        lat !== WAITC + 1) begin
      n_err++;
      $display("FAIL misalign_ld: rd=%h err=%b lat=%0d want %h %b %0d",
               rd, er, lat, TRAP ? 32'd0 : 32'hDEADBEEF, TRAP, WAITC + 1);
    end
    predict(1'b1, 32'h12, 32'hCAFE0000, kn, erd, eer);
    do_txn(1'b1, 32'h12, 32'hCAFE0000, 0, 1'b0, lat, rd, er, st, ok);
    predict(1'b0, 32'h10, 32'd0, kn, erd, eer);
    do_txn(1'b0, 32'h10, 32'd0, 0, 1'b0, lat, rd, er, st, ok);
    n_chk++;
    if (rd !== erd || txn_count !== exp_txn) begin
      n_err++;
      $display("FAIL misalign_st: rd=%h txn=%0d want %h %0d",
               rd, txn_count, erd, exp_txn);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] rd, erd;
    logic er, st, ok, kn, eer;
    predict(1'b1, 32'h20, 32'h11, kn, erd, eer);
    do_txn(1'b1, 32'h20, 32'h11, 0, 1'b0, lat, rd, er, st, ok);
    issue(1'b1, 32'h20, 32'h55);
    do_reset();
    predict(1'b0, 32'h20, 32'd0, kn, erd, eer);
    do_txn(1'b0, 32'h20, 32'd0, 0, 1'b0, lat, rd, er, st, ok);
    n_chk++;
    if (rd !== 32'h11 || txn_count !== 16'd1) begin
      n_err++;
      $display("FAIL reset_wait: rd=%h txn=%0d want 00000011 1",
               rd, txn_count);
    end
    issue(1'b0, 32'h20, 32'd0);
    wait_valid(lat);
    do_reset();
    @(negedge clk);
    n_chk++;
    if (lat < 0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 ||
        txn_count !== 16'd0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_resp: lat=%0d vld=%b rd=%h txn=%0d rdy=%b want 0 0 0 1",
               lat, rsp_valid, rsp_rdata, txn_count, req_ready);
    end
    predict(1'b1, 32'h34, 32'h99, kn, erd, eer);
    issue(1'b1, 32'h34, 32'h99);
    wait_valid(lat);
    do_reset();
    predict(1'b0, 32'h34, 32'd0, kn, erd, eer);
    do_txn(1'b0, 32'h34, 32'd0, 0, 1'b0, lat, rd, er, st, ok);
    n_chk++;
    if (rd !== 32'h99 || txn_count !== 16'd1) begin
      n_err++;
      $display("FAIL reset_commit: rd=%h txn=%0d want 00000099 1",
               rd, txn_count);
    end
  endtask

  task automatic test_random();
    int lat, hold;
    logic [31:0] a, d, rd, erd;
    logic w, er, st, ok, kn, eer;
    for (int k = 0; k < 60; k++) begin
      w    = 1'($urandom_range(0, 1));
      a    = {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'd0,
              6'($urandom_range(0, 15)), 2'b00, 2'b00};
      a    = a | 32'($urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0);
      d    = $urandom;
      hold = $urandom_range(0, 2);
      predict(w, a, d, kn, erd, eer);
      do_txn(w, a, d, hold, 1'b0, lat, rd, er, st, ok);
      n_chk++;
      if (lat !== WAITC + 1 || er !== eer || !st || !ok ||
          (kn && rd !== erd)) begin
        n_err++;
        $display("FAIL rand%0d: w=%b a=%h lat=%0d rd=%h err=%b st=%b idle=%b want lat %0d rd %h err %b",
                 k, w, a, lat, rd, er, st, ok, WAITC + 1, erd, eer);
      end
      n_chk++;
      if (txn_count !== exp_txn) begin
        n_err++;
        $display("FAIL rand_txn%0d: got %0d want %0d", k, txn_count, exp_txn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_backpressure();
    test_alias();
    test_misalign();
    test_reset_mid();
    test_random();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
